// File: rtl/cordic_sector_unfold.sv
// Output end of the CORDIC datapath: undoes the quadrant fold, wraps the angle
// into (-180,180] degrees and buffers results in a small valid/ready FIFO.
//
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   degree_in         folded angle from the pipeline, signed Q7.8 degrees
//   x_in, y_in        pipeline x/y, signed Q7.8
//   sector_in         quadrant fold amount s (0..3)
//   arctan_en_in      1 = vectoring/arctan result, 0 = rotation result
//   valid_in          pipeline word valid (no backpressure)
//   m_degree          unfolded angle, signed Q8.8 degrees
//   m_x, m_y          unfolded x/y
//   m_arctan_en       mode of head entry
//   m_valid, m_ready  output handshake
//   fifo_level        entries currently stored
//   overflow          sticky drop flag, cleared by clear_ovf
module cordic_sector_unfold #(
    parameter int DATA_WIDTH        = 16,
    parameter int DEG_IN_WIDTH      = 16,
    parameter int DEG_OUT_WIDTH     = 17,
    parameter int SECTOR_FLAG_WIDTH = 2,
    parameter int FIFO_DEPTH        = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DEG_IN_WIDTH-1:0]       degree_in,
    input  logic [DATA_WIDTH-1:0]         x_in,
    input  logic [DATA_WIDTH-1:0]         y_in,
    input  logic [SECTOR_FLAG_WIDTH-1:0]  sector_in,
    input  logic                          arctan_en_in,
    input  logic                          valid_in,
    output logic [DEG_OUT_WIDTH-1:0]      m_degree,
    output logic [DATA_WIDTH-1:0]         m_x,
    output logic [DATA_WIDTH-1:0]         m_y,
    output logic                          m_arctan_en,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    input  logic                          clear_ovf
);

    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = ADDR_W + 1;
    localparam int SUM_W  = 19;

    localparam logic [SUM_W-1:0] QUARTER_TURN = 19'd23040;
    localparam logic [SUM_W-1:0] HALF_TURN    = 19'd46080;
    localparam logic [SUM_W-1:0] FULL_TURN    = 19'd92160;

    // Two's-complement negate; the most negative value has no positive
    // counterpart, so it clamps to the most positive one.
    function automatic logic [DATA_WIDTH-1:0] sat_neg(
        input logic [DATA_WIDTH-1:0] v
    );
        if (v == {1'b1, {(DATA_WIDTH-1){1'b0}}})
            sat_neg = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        else
            sat_neg = -v;
    endfunction

    // Add back s quarter turns, then fold anything above +180 down by a
    // full turn so the result lands in (-180,180].
    function automatic logic [DEG_OUT_WIDTH-1:0] unfold_deg(
        input logic [DEG_IN_WIDTH-1:0] d,
        input logic [1:0]              s
    );
        logic [SUM_W-1:0] ext;
        logic [SUM_W-1:0] off;
        logic [SUM_W-1:0] sum;
        ext = {{(SUM_W-DEG_IN_WIDTH){d[DEG_IN_WIDTH-1]}}, d};
        unique case (s)
            2'd0:    off = '0;
            2'd1:    off = QUARTER_TURN;
            2'd2:    off = HALF_TURN;
            default: off = QUARTER_TURN + HALF_TURN;
        endcase
        sum = ext + off;
        if ($signed(sum) > $signed(HALF_TURN))
            sum = sum - FULL_TURN;
        unfold_deg = sum[DEG_OUT_WIDTH-1:0];
    endfunction

    // ---------------- stage 1: unfold correction ----------------
    logic [1:0]               w_sector;
    logic [DATA_WIDTH-1:0]    w_x_unf;
    logic [DATA_WIDTH-1:0]    w_y_unf;
    logic [DEG_OUT_WIDTH-1:0] w_deg_unf;

    assign w_sector  = sector_in[1:0];
    assign w_deg_unf = unfold_deg(degree_in, w_sector);

    always_comb begin
        w_x_unf = x_in;
        w_y_unf = y_in;
        if (!arctan_en_in) begin
            unique case (w_sector)
                2'd0: begin
                    w_x_unf = x_in;
                    w_y_unf = y_in;
                end
                2'd1: begin
                    w_x_unf = sat_neg(y_in);
                    w_y_unf = x_in;
                end
                2'd2: begin
                    w_x_unf = sat_neg(x_in);
                    w_y_unf = sat_neg(y_in);
                end
                default: begin
                    w_x_unf = y_in;
                    w_y_unf = sat_neg(x_in);
                end
            endcase
        end
    end

    logic                     r_s1_valid;
    logic                     r_s1_mode;
    logic [DEG_OUT_WIDTH-1:0] r_s1_deg;
    logic [DATA_WIDTH-1:0]    r_s1_x;
    logic [DATA_WIDTH-1:0]    r_s1_y;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_valid <= 1'b0;
            r_s1_mode  <= 1'b0;
            r_s1_deg   <= '0;
            r_s1_x     <= '0;
            r_s1_y     <= '0;
        end else begin
            r_s1_valid <= valid_in;
            if (valid_in) begin
                r_s1_mode <= arctan_en_in;
                r_s1_deg  <= w_deg_unf;
                r_s1_x    <= w_x_unf;
                r_s1_y    <= w_y_unf;
            end
        end
    end

    // ---------------- stage 2: output FIFO ----------------
    logic                     r_mem_mode [FIFO_DEPTH];
    logic [DEG_OUT_WIDTH-1:0] r_mem_deg  [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]    r_mem_x    [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]    r_mem_y    [FIFO_DEPTH];

    logic [ADDR_W-1:0]        r_wr;
    logic [ADDR_W-1:0]        r_rd;
    logic [LVL_W-1:0]         r_level;
    logic                     r_ovf;

    logic                     r_m_valid;
    logic                     r_m_mode;
    logic [DEG_OUT_WIDTH-1:0] r_m_deg;
    logic [DATA_WIDTH-1:0]    r_m_x;
    logic [DATA_WIDTH-1:0]    r_m_y;

    logic                     w_push;
    logic                     w_pop;
    logic                     w_full;
    logic                     w_drop;
    logic                     w_wr_en;
    logic [ADDR_W-1:0]        w_rd_nxt;
    logic [LVL_W-1:0]         w_avail;
    logic [LVL_W-1:0]         w_level_nxt;

    assign w_push      = r_s1_valid;
    assign w_pop       = r_m_valid & m_ready;
    assign w_full      = (r_level == LVL_W'(FIFO_DEPTH));
    assign w_drop      = w_push & w_full & ~w_pop;
    assign w_wr_en     = w_push & ~w_drop;
    assign w_rd_nxt    = r_rd + ADDR_W'(w_pop);
    // Entries that were already stored before this edge and survive it;
    // only these may be presented, so a fresh push shows up one cycle later.
    assign w_avail     = r_level - LVL_W'(w_pop);
    assign w_level_nxt = r_level + LVL_W'(w_wr_en) - LVL_W'(w_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem_mode[i] <= 1'b0;
                r_mem_deg[i]  <= '0;
                r_mem_x[i]    <= '0;
                r_mem_y[i]    <= '0;
            end
            r_wr      <= '0;
            r_rd      <= '0;
            r_level   <= '0;
            r_ovf     <= 1'b0;
            r_m_valid <= 1'b0;
            r_m_mode  <= 1'b0;
            r_m_deg   <= '0;
            r_m_x     <= '0;
            r_m_y     <= '0;
        end else begin
            if (w_wr_en) begin
                r_mem_mode[r_wr] <= r_s1_mode;
                r_mem_deg[r_wr]  <= r_s1_deg;
                r_mem_x[r_wr]    <= r_s1_x;
                r_mem_y[r_wr]    <= r_s1_y;
                r_wr             <= r_wr + 1'b1;
            end
            r_rd    <= w_rd_nxt;
            r_level <= w_level_nxt;

            // A drop in the same cycle as a clear keeps the flag set.
            if (w_drop)
                r_ovf <= 1'b1;
            else if (clear_ovf)
                r_ovf <= 1'b0;

            // The slot at w_rd_nxt was written on an earlier edge, and a
            // simultaneous write can only land on the slot being popped.
            r_m_valid <= (w_avail != '0);
            if (w_avail != '0) begin
                r_m_mode <= r_mem_mode[w_rd_nxt];
                r_m_deg  <= r_mem_deg[w_rd_nxt];
                r_m_x    <= r_mem_x[w_rd_nxt];
                r_m_y    <= r_mem_y[w_rd_nxt];
            end
        end
    end

    assign m_valid     = r_m_valid;
    assign m_arctan_en = r_m_mode;
    assign m_degree    = r_m_deg;
    assign m_x         = r_m_x;
    assign m_y         = r_m_y;
    assign fifo_level  = r_level;
    assign overflow    = r_ovf;

endmodule
